apb_master_bridge9: RTL and testbench

- Single-outstanding APB master that converts a valid/ready request/response handshake into APB setup/access transfers.
- Drives the signal set of the existing APB interface: paddr9, prwd9, pwdata9, penable9, psel9[15:0]. Samples prdata9, pready9 and pslverr9 from it.
- Sits directly upstream of the APB interface and its slaves. Bridges the CPU/bus-fabric side onto the peripheral bus.
- Bounds slave wait states with a programmable timeout.

---
 rtl/apb_master_bridge9_pkg.sv | 21 ++
 rtl/apb_master_bridge9_if.sv | 49 ++++
 rtl/apb_master_bridge9_timer.sv | 50 +++++
 rtl/apb_master_bridge9.sv | 170 +++++++++++++++++
 tb/tb_apb_master_bridge9.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/apb_master_bridge9_pkg.sv
// Shared types and helpers for the APB master bridge: FSM state encoding,
// the number of select lines on the peripheral bus and the select decoder.
package apb_bridge_pkg9;

    localparam int unsigned NUM_SLAVES9 = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_e;

    // Turn the 4-bit slave index taken from the address into a one-hot psel.
    function automatic logic [NUM_SLAVES9-1:0] slave_onehot(input logic [3:0] idx);
        logic [NUM_SLAVES9-1:0] one_s;
        one_s = {{(NUM_SLAVES9-1){1'b0}}, 1'b1};
        return one_s << idx;
    endfunction

endpackage

// File: rtl/apb_master_bridge9_if.sv
// Bundle of the request/response handshake and the APB signal set.
// The master modport is the bridge's view; slave is the view of whoever
// sits on the other side (request source, response sink and APB slaves).
interface apb_master_bridge9_if #(
    parameter int unsigned PADDR_WIDTH9  = 32,
    parameter int unsigned PWDATA_WIDTH9 = 32,
    parameter int unsigned PRDATA_WIDTH9 = 32
) ();
    import apb_bridge_pkg9::*;

    // request side
    logic                     req_valid9;
    logic                     req_ready9;
    logic [PADDR_WIDTH9-1:0]  req_addr9;
    logic                     req_write9;
    logic [PWDATA_WIDTH9-1:0] req_wdata9;

    // response side
    logic                     rsp_valid9;
    logic                     rsp_ready9;
    logic [PRDATA_WIDTH9-1:0] rsp_rdata9;
    logic                     rsp_err9;
    logic                     rsp_timeout9;

    // APB bus
    logic [PADDR_WIDTH9-1:0]  paddr9;
    logic                     prwd9;
    logic [PWDATA_WIDTH9-1:0] pwdata9;
    logic                     penable9;
    logic [NUM_SLAVES9-1:0]   psel9;
    logic [PRDATA_WIDTH9-1:0] prdata9;
    logic                     pready9;
    logic                     pslverr9;

    modport master (
        input  req_valid9, req_addr9, req_write9, req_wdata9, rsp_ready9,
               prdata9, pready9, pslverr9,
        output req_ready9, rsp_valid9, rsp_rdata9, rsp_err9, rsp_timeout9,
               paddr9, prwd9, pwdata9, penable9, psel9
    );

    modport slave (
        output req_valid9, req_addr9, req_write9, req_wdata9, rsp_ready9,
               prdata9, pready9, pslverr9,
        input  req_ready9, rsp_valid9, rsp_rdata9, rsp_err9, rsp_timeout9,
               paddr9, prwd9, pwdata9, penable9, psel9
    );

endinterface

// File: rtl/apb_master_bridge9_timer.sv
// ACCESS-phase wait-state counter. 'expired' is high during the cycle in
// which one more wait state would bring the count to TIMEOUT9, so the FSM
// can abort on that same edge unless pready arrives first. TIMEOUT9 = 0
// disables expiry; the counter then saturates instead of wrapping.
module apb_wait_timer9 #(
    parameter int unsigned TIMEOUT9 = 256
) (
    input  logic pclock9,
    input  logic preset9,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CNT_W  = (TIMEOUT9 > 0) ? $clog2(TIMEOUT9 + 1) : 1;
    localparam int unsigned LAST_I = (TIMEOUT9 > 0) ? (TIMEOUT9 - 1) : 0;
    localparam logic [CNT_W-1:0] LAST_C = LAST_I[CNT_W-1:0];
    localparam logic [CNT_W-1:0] ZERO_C = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] MAX_C  = {CNT_W{1'b1}};
    localparam logic             EN_C   = (TIMEOUT9 != 0);

    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_inc_s;
    logic             expired_r;

    // Next count value when another wait state is seen.
    always_comb begin
        cnt_inc_s = cnt_r + CNT_W'(1);
    end

    // Count wait states and pre-compute the expiry flag for the next cycle.
    always_ff @(posedge pclock9 or negedge preset9) begin
        if (!preset9) begin
            cnt_r     <= ZERO_C;
            expired_r <= 1'b0;
        end else if (clear) begin
            cnt_r     <= ZERO_C;
            expired_r <= EN_C && (LAST_C == ZERO_C);
        end else if (enable && (cnt_r != MAX_C)) begin
            cnt_r     <= cnt_inc_s;
            expired_r <= EN_C && (cnt_inc_s == LAST_C);
        end else begin
            cnt_r     <= cnt_r;
            expired_r <= expired_r;
        end
    end

    assign expired = expired_r;

endmodule

// File: rtl/apb_master_bridge9.sv
// Single-outstanding APB master: accepts one valid/ready request, runs the
// APB SETUP/ACCESS sequence, and holds the response until it is consumed.
// Slave wait states are bounded by a programmable timeout.
module apb_master_bridge9
    import apb_bridge_pkg9::*;
#(
    parameter int unsigned PADDR_WIDTH9  = 32,
    parameter int unsigned PWDATA_WIDTH9 = 32,
    parameter int unsigned PRDATA_WIDTH9 = 32,
    parameter int unsigned SEL_LSB9      = 12,
    parameter int unsigned TIMEOUT9      = 256
) (
    input  logic                 pclock9,
    input  logic                 preset9,
    apb_master_bridge9_if.master bus
);

    state_e                   state_r;
    logic                     req_ready_r;
    logic                     rsp_valid_r;
    logic [PRDATA_WIDTH9-1:0] rsp_rdata_r;
    logic                     rsp_err_r;
    logic                     rsp_timeout_r;
    logic [PADDR_WIDTH9-1:0]  paddr_r;
    logic                     prwd_r;
    logic [PWDATA_WIDTH9-1:0] pwdata_r;
    logic                     penable_r;
    logic [NUM_SLAVES9-1:0]   psel_r;

    logic                     accept_s;
    logic                     wait_en_s;
    logic                     expired_s;
    logic [3:0]               sel_idx_s;

    // Handshake qualifiers: request acceptance and wait-state counting.
    always_comb begin
        accept_s  = 1'b0;
        wait_en_s = 1'b0;
        sel_idx_s = bus.req_addr9[SEL_LSB9+3:SEL_LSB9];
        if (state_r == IDLE) begin
            accept_s = bus.req_valid9 && req_ready_r;
        end else begin
            accept_s = 1'b0;
        end
        if (state_r == ACCESS) begin
            wait_en_s = !bus.pready9;
        end else begin
            wait_en_s = 1'b0;
        end
    end

    // The counter restarts on every accept, i.e. on entry to SETUP.
    apb_wait_timer9 #(
        .TIMEOUT9 (TIMEOUT9)
    ) u_wait_timer (
        .pclock9 (pclock9),
        .preset9 (preset9),
        .clear   (accept_s),
        .enable  (wait_en_s),
        .expired (expired_s)
    );

    // Transfer sequencer with all bus and response outputs registered.
    always_ff @(posedge pclock9 or negedge preset9) begin
        if (!preset9) begin
            state_r       <= IDLE;
            req_ready_r   <= 1'b0;
            rsp_valid_r   <= 1'b0;
            rsp_rdata_r   <= {PRDATA_WIDTH9{1'b0}};
            rsp_err_r     <= 1'b0;
            rsp_timeout_r <= 1'b0;
            paddr_r       <= {PADDR_WIDTH9{1'b0}};
            prwd_r        <= 1'b0;
            pwdata_r      <= {PWDATA_WIDTH9{1'b0}};
            penable_r     <= 1'b0;
            psel_r        <= {NUM_SLAVES9{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        state_r     <= SETUP;
                        req_ready_r <= 1'b0;
                        paddr_r     <= bus.req_addr9;
                        prwd_r      <= bus.req_write9;
                        pwdata_r    <= bus.req_write9 ? bus.req_wdata9 : {PWDATA_WIDTH9{1'b0}};
                        psel_r      <= slave_onehot(sel_idx_s);
                        penable_r   <= 1'b0;
                    end else begin
                        // also covers the first cycle after reset release
                        state_r     <= IDLE;
                        req_ready_r <= 1'b1;
                    end
                end

                SETUP: begin
                    state_r   <= ACCESS;
                    penable_r <= 1'b1;
                end

                ACCESS: begin
                    if (bus.pready9) begin
                        // pready wins even when the timeout fires on this edge
                        state_r       <= RESP;
                        rsp_valid_r   <= 1'b1;
                        rsp_rdata_r   <= prwd_r ? {PRDATA_WIDTH9{1'b0}} : bus.prdata9;
                        rsp_err_r     <= bus.pslverr9;
                        rsp_timeout_r <= 1'b0;
                        paddr_r       <= {PADDR_WIDTH9{1'b0}};
                        prwd_r        <= 1'b0;
                        pwdata_r      <= {PWDATA_WIDTH9{1'b0}};
                        penable_r     <= 1'b0;
                        psel_r        <= {NUM_SLAVES9{1'b0}};
                    end else if (expired_s) begin
                        state_r       <= RESP;
                        rsp_valid_r   <= 1'b1;
                        rsp_rdata_r   <= {PRDATA_WIDTH9{1'b0}};
                        rsp_err_r     <= 1'b1;
                        rsp_timeout_r <= 1'b1;
                        paddr_r       <= {PADDR_WIDTH9{1'b0}};
                        prwd_r        <= 1'b0;
                        pwdata_r      <= {PWDATA_WIDTH9{1'b0}};
                        penable_r     <= 1'b0;
                        psel_r        <= {NUM_SLAVES9{1'b0}};
                    end else begin
                        state_r <= ACCESS;
                    end
                end

                RESP: begin
                    if (bus.rsp_ready9) begin
                        state_r       <= IDLE;
                        req_ready_r   <= 1'b1;
                        rsp_valid_r   <= 1'b0;
                        rsp_rdata_r   <= {PRDATA_WIDTH9{1'b0}};
                        rsp_err_r     <= 1'b0;
                        rsp_timeout_r <= 1'b0;
                    end else begin
                        state_r <= RESP;
                    end
                end

                default: begin
                    state_r       <= IDLE;
                    req_ready_r   <= 1'b0;
                    rsp_valid_r   <= 1'b0;
                    rsp_rdata_r   <= {PRDATA_WIDTH9{1'b0}};
                    rsp_err_r     <= 1'b0;
                    rsp_timeout_r <= 1'b0;
                    paddr_r       <= {PADDR_WIDTH9{1'b0}};
                    prwd_r        <= 1'b0;
                    pwdata_r      <= {PWDATA_WIDTH9{1'b0}};
                    penable_r     <= 1'b0;
                    psel_r        <= {NUM_SLAVES9{1'b0}};
                end
            endcase
        end
    end

    assign bus.req_ready9   = req_ready_r;
    assign bus.rsp_valid9   = rsp_valid_r;
    assign bus.rsp_rdata9   = rsp_rdata_r;
    assign bus.rsp_err9     = rsp_err_r;
    assign bus.rsp_timeout9 = rsp_timeout_r;
    assign bus.paddr9       = paddr_r;
    assign bus.prwd9        = prwd_r;
    assign bus.pwdata9      = pwdata_r;
    assign bus.penable9     = penable_r;
    assign bus.psel9        = psel_r;

endmodule

// File: tb/tb_apb_master_bridge9.sv
// Directed bench for apb_master_bridge9 (TIMEOUT9 = 4). Inputs are driven
// and outputs sampled on the falling clock edge.
module tb_apb_master_bridge9;

    logic pclock9;
    logic preset9;
    int   checks;
    int   errors;

    apb_master_bridge9_if #(
        .PADDR_WIDTH9  (32),
        .PWDATA_WIDTH9 (32),
        .PRDATA_WIDTH9 (32)
    ) bus ();

    apb_master_bridge9 #(
        .PADDR_WIDTH9  (32),
        .PWDATA_WIDTH9 (32),
        .PRDATA_WIDTH9 (32),
        .SEL_LSB9      (12),
        .TIMEOUT9      (4)
    ) dut (
        .pclock9 (pclock9),
        .preset9 (preset9),
        .bus     (bus.master)
    );

    initial pclock9 = 1'b0;
    always #5 pclock9 = ~pclock9;

    task automatic offer(input logic [31:0] addr, input logic wr, input logic [31:0] wdata);
        bus.req_valid9 = 1'b1;
        bus.req_addr9  = addr;
        bus.req_write9 = wr;
        bus.req_wdata9 = wdata;
    endtask

    task automatic test_reset;
        #1;
        checks++; if (bus.req_ready9 !== 1'b0) begin errors++; $display("FAIL rst_req_ready: got %b want 0", bus.req_ready9); end
        checks++; if (bus.rsp_valid9 !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid: got %b want 0", bus.rsp_valid9); end
        checks++; if (bus.psel9 !== 16'h0000) begin errors++; $display("FAIL rst_psel: got %h want 0000", bus.psel9); end
        checks++; if (bus.penable9 !== 1'b0) begin errors++; $display("FAIL rst_penable: got %b want 0", bus.penable9); end
        checks++; if (bus.paddr9 !== 32'h0) begin errors++; $display("FAIL rst_paddr: got %h want 0", bus.paddr9); end
        repeat (2) @(negedge pclock9);
        preset9 = 1'b1;
        @(negedge pclock9);
        checks++; if (bus.req_ready9 !== 1'b1) begin errors++; $display("FAIL rst_idle_ready: got %b want 1", bus.req_ready9); end
        checks++; if (bus.psel9 !== 16'h0000) begin errors++; $display("FAIL rst_idle_psel: got %h want 0000", bus.psel9); end
    endtask

    task automatic test_write;
        offer(32'h0000_3010, 1'b1, 32'hCAFE_F00D);
        bus.pready9 = 1'b1; bus.pslverr9 = 1'b0; bus.prdata9 = 32'hFFFF_FFFF; bus.rsp_ready9 = 1'b0;
        @(negedge pclock9);
        bus.req_valid9 = 1'b0;
        checks++; if (bus.psel9 !== 16'h0008) begin errors++; $display("FAIL wr_setup_psel: got %h want 0008", bus.psel9); end
        checks++; if (bus.penable9 !== 1'b0) begin errors++; $display("FAIL wr_setup_penable: got %b want 0", bus.penable9); end
        checks++; if (bus.paddr9 !== 32'h0000_3010) begin errors++; $display("FAIL wr_setup_paddr: got %h want 00003010", bus.paddr9); end
        checks++; if (bus.prwd9 !== 1'b1) begin errors++; $display("FAIL wr_setup_prwd: got %b want 1", bus.prwd9); end
        checks++; if (bus.pwdata9 !== 32'hCAFE_F00D) begin errors++; $display("FAIL wr_setup_pwdata: got %h want cafef00d", bus.pwdata9); end
        checks++; if (bus.req_ready9 !== 1'b0) begin errors++; $display("FAIL wr_setup_ready: got %b want 0", bus.req_ready9); end
        @(negedge pclock9);
        checks++; if (bus.penable9 !== 1'b1) begin errors++; $display("FAIL wr_access_penable: got %b want 1", bus.penable9); end
        checks++; if (bus.psel9 !== 16'h0008) begin errors++; $display("FAIL wr_access_psel: got %h want 0008", bus.psel9); end
        checks++; if (bus.rsp_valid9 !== 1'b0) begin errors++; $display("FAIL wr_early_rsp: got %b want 0", bus.rsp_valid9); end
        @(negedge pclock9);
        checks++; if (bus.rsp_valid9 !== 1'b1) begin errors++; $display("FAIL wr_rsp_valid: got %b want 1", bus.rsp_valid9); end
        checks++; if (bus.rsp_err9 !== 1'b0) begin errors++; $display("FAIL wr_rsp_err: got %b want 0", bus.rsp_err9); end
        checks++; if (bus.rsp_rdata9 !== 32'h0) begin errors++; $display("FAIL wr_rsp_rdata: got %h want 0", bus.rsp_rdata9); end
        checks++; if (bus.rsp_timeout9 !== 1'b0) begin errors++; $display("FAIL wr_rsp_timeout: got %b want 0", bus.rsp_timeout9); end
        checks++; if ({bus.psel9, bus.penable9} !== 17'h0) begin errors++; $display("FAIL wr_bus_idle: got %h want 0", {bus.psel9, bus.penable9}); end
        bus.rsp_ready9 = 1'b1;
        @(negedge pclock9);
        checks++; if (bus.rsp_valid9 !== 1'b0) begin errors++; $display("FAIL wr_rsp_drop: got %b want 0", bus.rsp_valid9); end
        checks++; if (bus.req_ready9 !== 1'b1) begin errors++; $display("FAIL wr_ready_back: got %b want 1", bus.req_ready9); end
        bus.rsp_ready9 = 1'b0;
    endtask

    task automatic test_read_wait;
        offer(32'h0000_F004, 1'b0, 32'hAAAA_5555);
        bus.pready9 = 1'b0; bus.prdata9 = 32'h0BAD_0BAD;
        @(negedge pclock9);
        bus.req_valid9 = 1'b0;
        checks++; if (bus.psel9 !== 16'h8000) begin errors++; $display("FAIL rd_setup_psel: got %h want 8000", bus.psel9); end
        checks++; if (bus.pwdata9 !== 32'h0) begin errors++; $display("FAIL rd_setup_pwdata: got %h want 0", bus.pwdata9); end
        checks++; if (bus.prwd9 !== 1'b0) begin errors++; $display("FAIL rd_setup_prwd: got %b want 0", bus.prwd9); end
        for (int i = 0; i < 4; i++) begin
            @(negedge pclock9);
            checks++; if ({bus.psel9, bus.penable9, bus.rsp_valid9} !== {16'h8000, 1'b1, 1'b0}) begin errors++; $display("FAIL rd_access_%0d: got psel/en/rv %h want 8000/1/0", i, {bus.psel9, bus.penable9, bus.rsp_valid9}); end
        end
        // fourth ACCESS cycle: pready coincides with the timeout boundary
        bus.pready9 = 1'b1; bus.prdata9 = 32'h1234_5678;
        @(negedge pclock9);
        bus.pready9 = 1'b0; bus.prdata9 = 32'hFFFF_0000;
        checks++; if (bus.rsp_valid9 !== 1'b1) begin errors++; $display("FAIL rd_rsp_valid: got %b want 1", bus.rsp_valid9); end
        checks++; if (bus.rsp_rdata9 !== 32'h1234_5678) begin errors++; $display("FAIL rd_rsp_rdata: got %h want 12345678", bus.rsp_rdata9); end
        checks++; if ({bus.rsp_err9, bus.rsp_timeout9} !== 2'b00) begin errors++; $display("FAIL rd_rsp_flags: got %b want 00", {bus.rsp_err9, bus.rsp_timeout9}); end
        @(negedge pclock9);
        checks++; if (bus.rsp_rdata9 !== 32'h1234_5678) begin errors++; $display("FAIL rd_rsp_hold: got %h want 12345678", bus.rsp_rdata9); end
        bus.rsp_ready9 = 1'b1;
        @(negedge pclock9);
        checks++; if (bus.rsp_valid9 !== 1'b0) begin errors++; $display("FAIL rd_rsp_drop: got %b want 0", bus.rsp_valid9); end
        bus.rsp_ready9 = 1'b0;
    endtask

    task automatic test_slverr;
        offer(32'h0000_1000, 1'b0, 32'h0);
        bus.pready9 = 1'b1; bus.pslverr9 = 1'b1; bus.prdata9 = 32'hDEAD_BEEF; bus.rsp_ready9 = 1'b1;
        @(negedge pclock9);
        bus.req_valid9 = 1'b0;
        checks++; if (bus.psel9 !== 16'h0002) begin errors++; $display("FAIL err_psel: got %h want 0002", bus.psel9); end
        @(negedge pclock9);
        @(negedge pclock9);
        bus.pslverr9 = 1'b0;
        checks++; if (bus.rsp_valid9 !== 1'b1) begin errors++; $display("FAIL err_rsp_valid: got %b want 1", bus.rsp_valid9); end
        checks++; if ({bus.rsp_err9, bus.rsp_timeout9} !== 2'b10) begin errors++; $display("FAIL err_rsp_flags: got %b want 10", {bus.rsp_err9, bus.rsp_timeout9}); end
        checks++; if (bus.rsp_rdata9 !== 32'hDEAD_BEEF) begin errors++; $display("FAIL err_rsp_rdata: got %h want deadbeef", bus.rsp_rdata9); end
        @(negedge pclock9);
        checks++; if ({bus.rsp_valid9, bus.req_ready9} !== 2'b01) begin errors++; $display("FAIL err_back_idle: got %b want 01", {bus.rsp_valid9, bus.req_ready9}); end
        bus.rsp_ready9 = 1'b0;
    endtask

    task automatic test_timeout;
        offer(32'h0000_2000, 1'b0, 32'h0);
        bus.pready9 = 1'b0; bus.prdata9 = 32'h7777_7777;
        @(negedge pclock9);
        bus.req_valid9 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge pclock9);
            checks++; if ({bus.psel9, bus.penable9, bus.rsp_valid9} !== {16'h0004, 1'b1, 1'b0}) begin errors++; $display("FAIL to_access_%0d: got psel/en/rv %h want 0004/1/0", i, {bus.psel9, bus.penable9, bus.rsp_valid9}); end
        end
        @(negedge pclock9);
        checks++; if (bus.rsp_valid9 !== 1'b1) begin errors++; $display("FAIL to_rsp_valid: got %b want 1", bus.rsp_valid9); end
        checks++; if ({bus.rsp_err9, bus.rsp_timeout9} !== 2'b11) begin errors++; $display("FAIL to_rsp_flags: got %b want 11", {bus.rsp_err9, bus.rsp_timeout9}); end
        checks++; if (bus.rsp_rdata9 !== 32'h0) begin errors++; $display("FAIL to_rsp_rdata: got %h want 0", bus.rsp_rdata9); end
        checks++; if ({bus.psel9, bus.penable9} !== 17'h0) begin errors++; $display("FAIL to_bus_idle: got %h want 0", {bus.psel9, bus.penable9}); end
        bus.rsp_ready9 = 1'b1;
        @(negedge pclock9);
        checks++; if (bus.rsp_valid9 !== 1'b0) begin errors++; $display("FAIL to_rsp_drop: got %b want 0", bus.rsp_valid9); end
        bus.rsp_ready9 = 1'b0;
    endtask

    task automatic test_back_to_back;
        offer(32'h0000_5020, 1'b1, 32'h0BAD_C0DE);
        bus.pready9 = 1'b1; bus.prdata9 = 32'h0000_A5A5; bus.rsp_ready9 = 1'b0;
        @(negedge pclock9);
        // second request offered immediately and kept valid
        offer(32'h0000_A040, 1'b0, 32'h0);
        checks++; if ({bus.psel9, bus.paddr9} !== {16'h0020, 32'h0000_5020}) begin errors++; $display("FAIL b2b_first_setup: got %h want 0020/00005020", {bus.psel9, bus.paddr9}); end
        @(negedge pclock9);
        for (int i = 0; i < 5; i++) begin
            @(negedge pclock9);
            checks++; if ({bus.rsp_valid9, bus.rsp_err9, bus.req_ready9} !== 3'b100) begin errors++; $display("FAIL b2b_stall_%0d: got rv/err/rr %b want 100", i, {bus.rsp_valid9, bus.rsp_err9, bus.req_ready9}); end
            checks++; if ({bus.rsp_rdata9, bus.psel9} !== {32'h0, 16'h0}) begin errors++; $display("FAIL b2b_stall_data_%0d: got %h want 0", i, {bus.rsp_rdata9, bus.psel9}); end
        end
        bus.rsp_ready9 = 1'b1;
        @(negedge pclock9);
        bus.rsp_ready9 = 1'b0;
        checks++; if ({bus.rsp_valid9, bus.req_ready9} !== 2'b01) begin errors++; $display("FAIL b2b_idle: got %b want 01", {bus.rsp_valid9, bus.req_ready9}); end
        checks++; if (bus.psel9 !== 16'h0000) begin errors++; $display("FAIL b2b_idle_psel: got %h want 0000", bus.psel9); end
        @(negedge pclock9);
        bus.req_valid9 = 1'b0;
        checks++; if ({bus.psel9, bus.paddr9} !== {16'h0400, 32'h0000_A040}) begin errors++; $display("FAIL b2b_second_setup: got %h want 0400/0000a040", {bus.psel9, bus.paddr9}); end
        checks++; if ({bus.prwd9, bus.req_ready9} !== 2'b00) begin errors++; $display("FAIL b2b_second_ctl: got %b want 00", {bus.prwd9, bus.req_ready9}); end
        @(negedge pclock9);
        @(negedge pclock9);
        checks++; if ({bus.rsp_valid9, bus.rsp_rdata9} !== {1'b1, 32'h0000_A5A5}) begin errors++; $display("FAIL b2b_second_rsp: got %h want 1/0000a5a5", {bus.rsp_valid9, bus.rsp_rdata9}); end
        bus.rsp_ready9 = 1'b1;
        @(negedge pclock9);
        bus.rsp_ready9 = 1'b0;
    endtask

    task automatic test_reset_mid;
        offer(32'h0000_6000, 1'b0, 32'h0);
        bus.pready9 = 1'b0; bus.prdata9 = 32'h3C3C_3C3C;
        @(negedge pclock9);
        bus.req_valid9 = 1'b0;
        @(negedge pclock9);
        checks++; if ({bus.psel9, bus.penable9} !== {16'h0040, 1'b1}) begin errors++; $display("FAIL rm_in_access: got %h want 0040/1", {bus.psel9, bus.penable9}); end
        #2 preset9 = 1'b0;
        #1;
        checks++; if ({bus.psel9, bus.penable9, bus.paddr9, bus.pwdata9} !== 81'h0) begin errors++; $display("FAIL rm_apb_zero: got %h want 0", {bus.psel9, bus.penable9, bus.paddr9, bus.pwdata9}); end
        checks++; if ({bus.rsp_valid9, bus.rsp_err9, bus.rsp_timeout9, bus.req_ready9} !== 4'h0) begin errors++; $display("FAIL rm_ctl_zero: got %b want 0000", {bus.rsp_valid9, bus.rsp_err9, bus.rsp_timeout9, bus.req_ready9}); end
        bus.pready9 = 1'b1;
        repeat (2) @(negedge pclock9);
        preset9 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge pclock9);
            checks++; if ({bus.rsp_valid9, bus.psel9} !== 17'h0) begin errors++; $display("FAIL rm_no_rsp_%0d: got %h want 0", i, {bus.rsp_valid9, bus.psel9}); end
        end
        checks++; if (bus.req_ready9 !== 1'b1) begin errors++; $display("FAIL rm_ready: got %b want 1", bus.req_ready9); end
        offer(32'h0000_2008, 1'b1, 32'h55AA_33CC);
        bus.rsp_ready9 = 1'b1;
        @(negedge pclock9);
        bus.req_valid9 = 1'b0;
        checks++; if ({bus.psel9, bus.pwdata9} !== {16'h0004, 32'h55AA_33CC}) begin errors++; $display("FAIL rm_fresh_setup: got %h want 0004/55aa33cc", {bus.psel9, bus.pwdata9}); end
        @(negedge pclock9);
        checks++; if (bus.penable9 !== 1'b1) begin errors++; $display("FAIL rm_fresh_access: got %b want 1", bus.penable9); end
        @(negedge pclock9);
        checks++; if ({bus.rsp_valid9, bus.rsp_err9, bus.rsp_timeout9, bus.rsp_rdata9} !== {3'b100, 32'h0}) begin errors++; $display("FAIL rm_fresh_rsp: got %h want 100/0", {bus.rsp_valid9, bus.rsp_err9, bus.rsp_timeout9, bus.rsp_rdata9}); end
        @(negedge pclock9);
        bus.rsp_ready9 = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        preset9 = 1'b0;
        bus.req_valid9 = 1'b0;
        bus.req_addr9  = 32'h0;
        bus.req_write9 = 1'b0;
        bus.req_wdata9 = 32'h0;
        bus.rsp_ready9 = 1'b0;
        bus.prdata9    = 32'h0;
        bus.pready9    = 1'b0;
        bus.pslverr9   = 1'b0;

        test_reset;
        test_write;
        test_read_wait;
        test_slverr;
        test_timeout;
        test_back_to_back;
        test_reset_mid;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
